// File: rtl/vj_pkg.sv
// Shared constants and types for the integral-image rectangle sum reader.
package vj_pkg;

   localparam int unsigned IMG_W     = 320;
   localparam int unsigned IMG_H     = 240;
   localparam int unsigned II_STRIDE = IMG_W + 1;
   localparam int unsigned ADDR_W    = 17;
   localparam int unsigned II_DATA_W = 32;
   // Corner coordinates are summed at this width so x+w / y+h cannot overflow before the bounds check.
   localparam int unsigned EXT_W     = 10;

   typedef enum logic [1:0] {
      CORNER_A = 2'd0,
      CORNER_B = 2'd1,
      CORNER_C = 2'd2,
      CORNER_D = 2'd3
   } corner_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_OUT   = 2'd3
   } state_e;

   typedef struct packed {
      logic    vld;
      corner_e corner;
   } rd_tag_t;

   // B and C are subtracted, A and D added.
   function automatic logic corner_negative(corner_e c);
      return (c == CORNER_B) || (c == CORNER_C);
   endfunction

endpackage

// File: rtl/vj_ii_addr_gen.sv
// Integral-image address: row * (IMG_W+1) + col.
module vj_ii_addr_gen
   import vj_pkg::*;
(
   input  logic [8:0]        col_i,
   input  logic [7:0]        row_i,
   output logic [ADDR_W-1:0] addr_o
);

   // Stride 321 = 256 + 64 + 1, so the multiply reduces to two shifts and three adds.
   assign addr_o = (ADDR_W'(row_i) << 8) + (ADDR_W'(row_i) << 6)
                 + ADDR_W'(row_i) + ADDR_W'(col_i);

endmodule

// File: rtl/vj_rect_sum_reader.sv
// Reads the four integral-image corners of a rectangle and returns A - B - C + D.
module vj_rect_sum_reader
   import vj_pkg::*;
#(
   parameter int unsigned RD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ii_ready,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [8:0]           req_x,
   input  logic [7:0]           req_y,
   input  logic [8:0]           req_w,
   input  logic [7:0]           req_h,
   output logic                 ii_re,
   output logic [ADDR_W-1:0]    ii_raddr,
   input  logic [II_DATA_W-1:0] ii_rdata,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [II_DATA_W-1:0] res_sum,
   output logic                 res_err
);

   state_e                state_q, state_d;
   logic [1:0]            cnt_q, cnt_d;
   logic                  req_ready_q, req_ready_d;
   logic                  ii_re_q, ii_re_d;
   logic [ADDR_W-1:0]     ii_raddr_q, ii_raddr_d;
   logic                  res_valid_q, res_valid_d;
   logic [II_DATA_W-1:0]  res_sum_q, res_sum_d;
   logic                  res_err_q, res_err_d;

   logic [8:0]            x_q, x2_q;
   logic [7:0]            y_q, y2_q;
   logic                  err_q;
   logic [II_DATA_W-1:0]  acc_q;
   rd_tag_t               tag_q [RD_LAT];
   rd_tag_t               tag_out;

   logic [EXT_W-1:0]      x_end, y_end;
   logic                  bounds_err, accept;
   logic [8:0]            ag_col;
   logic [7:0]            ag_row;
   logic [ADDR_W-1:0]     ag_addr;

   assign x_end      = EXT_W'(req_x) + EXT_W'(req_w);
   assign y_end      = EXT_W'(req_y) + EXT_W'(req_h);
   assign bounds_err = (x_end > EXT_W'(IMG_W)) || (y_end > EXT_W'(IMG_H));
   assign accept     = (state_q == ST_IDLE) && req_valid && req_ready_q;
   assign tag_out    = tag_q[RD_LAT-1];

   // Address of the corner issued on the next cycle: A straight from the request, then B, C, D.
   always_comb begin
      ag_col = x_q;
      ag_row = y_q;
      if (state_q == ST_IDLE) begin
         ag_col = req_x;
         ag_row = req_y;
      end else begin
         unique case (cnt_q)
            2'd0:    ag_col = x2_q;
            2'd1:    ag_row = y2_q;
            default: begin
               ag_col = x2_q;
               ag_row = y2_q;
            end
         endcase
      end
   end

   vj_ii_addr_gen u_addr_gen (
      .col_i  (ag_col),
      .row_i  (ag_row),
      .addr_o (ag_addr)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ii_re_d     = 1'b0;
      ii_raddr_d  = ii_raddr_q;
      res_valid_d = res_valid_q;
      res_sum_d   = res_sum_q;
      res_err_d   = res_err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               cnt_d = 2'd0;
               if (bounds_err) begin
                  state_d = ST_OUT;
               end else begin
                  state_d    = ST_ISSUE;
                  ii_re_d    = 1'b1;
                  ii_raddr_d = ag_addr;
               end
            end
         end
         ST_ISSUE: begin
            if (cnt_q == 2'd3) begin
               state_d = ST_DRAIN;
               cnt_d   = 2'd0;
            end else begin
               cnt_d      = cnt_q + 2'd1;
               ii_re_d    = 1'b1;
               ii_raddr_d = ag_addr;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == 2'(RD_LAT - 1)) state_d = ST_OUT;
            else                         cnt_d   = cnt_q + 2'd1;
         end
         ST_OUT: begin
            // Result loads once on entry, then stays frozen until the consumer takes it.
            if (!res_valid_q) begin
               res_valid_d = 1'b1;
               res_sum_d   = err_q ? '0 : acc_q;
               res_err_d   = err_q;
            end else if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      req_ready_d = (state_d == ST_IDLE) && ii_ready;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 2'd0;
         req_ready_q <= 1'b0;
         ii_re_q     <= 1'b0;
         ii_raddr_q  <= '0;
         res_valid_q <= 1'b0;
         res_sum_q   <= '0;
         res_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         ii_re_q     <= ii_re_d;
         ii_raddr_q  <= ii_raddr_d;
         res_valid_q <= res_valid_d;
         res_sum_q   <= res_sum_d;
         res_err_q   <= res_err_d;
      end
   end

   // Request capture; far corners are only used when in bounds, so truncation is safe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q   <= '0;
         y_q   <= '0;
         x2_q  <= '0;
         y2_q  <= '0;
         err_q <= 1'b0;
      end else if (accept) begin
         x_q   <= req_x;
         y_q   <= req_y;
         x2_q  <= 9'(x_end);
         y2_q  <= 8'(y_end);
         err_q <= bounds_err;
      end
   end

   // Tag pipe aligns each returning word with the corner that requested it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0] <= '{vld: ii_re_q, corner: corner_e'(cnt_q)};
         for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
      end else if (accept) begin
         acc_q <= '0;
      end else if (tag_out.vld) begin
         acc_q <= corner_negative(tag_out.corner) ? (acc_q - ii_rdata) : (acc_q + ii_rdata);
      end
   end

   assign req_ready = req_ready_q;
   assign ii_re     = ii_re_q;
   assign ii_raddr  = ii_raddr_q;
   assign res_valid = res_valid_q;
   assign res_sum   = res_sum_q;
   assign res_err   = res_err_q;

endmodule
